// File: rtl/dice_roller.sv
// dice_roller: produces a pair of pseudo-random die values (1..6) on request.
// A free-running 16-bit Galois LFSR picks the die2 step size while the dice
// tumble for SETTLE_CYCLES clocks; the result is then held behind a
// valid/ready handshake until the consumer takes it.
// Optional feature: define DICE_SUM_EN to add the registered 'sum' output.
//
// Handshake: 'valid' rises when a result is final and stays high, with
// die1/die2/sum frozen, until an edge where valid=1 and ready=1 (the
// transfer). 'ready' while valid=0 is ignored. 'roll' is only sampled in
// IDLE; a roll while busy is dropped, not queued.
//
// The FSM state is kept in the 'state' signal (type state_t) so checkers can
// bind to it directly.

module dice_roller #(
    parameter logic [15:0] SEED          = 16'hACE1,
    parameter int          SETTLE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       roll,
    input  logic       ready,
    output logic       busy,
    output logic       valid,
    output logic [2:0] die1,
    output logic [2:0] die2
`ifdef DICE_SUM_EN
    ,
    output logic [3:0] sum
`endif
);

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [7:0]  CNT_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TUMBLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;
    logic [7:0]  cnt;
    logic [2:0]  die1_next;
    logic [2:0]  die2_next;
    logic        busy_next;
    logic        valid_next;

    // Die1 always advances by one face, wrapping 6 -> 1.
    function automatic logic [2:0] step_one(input logic [2:0] d);
        return (d == 3'd6) ? 3'd1 : d + 3'd1;
    endfunction

    // Die2 advances by one or two faces, wrapping within 1..6.
    function automatic logic [2:0] step_two(input logic [2:0] d, input logic two);
        logic [2:0] r;
        if (!two) begin
            r = step_one(d);
        end else begin
            case (d)
                3'd5:    r = 3'd1;
                3'd6:    r = 3'd2;
                default: r = d + 3'd2;
            endcase
        end
        return r;
    endfunction

    // Galois right-shift LFSR next value.
    always_comb begin
        lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
    end

    // LFSR runs every clock in every state so roll timing adds entropy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED_EFF;
        end else begin
            lfsr <= lfsr_next;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (roll)        state_next = TUMBLE;
            TUMBLE:  if (cnt == 8'd0) state_next = HOLD;
            HOLD:    if (ready)       state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // Tumble counter: loaded on the accepted roll, counts down while tumbling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (state == IDLE && roll) begin
            cnt <= CNT_LOAD;
        end else if (state == TUMBLE && cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        die1_next  = die1;
        die2_next  = die2;
        busy_next  = (state_next != IDLE);
        valid_next = (state_next == HOLD);
        if (state == TUMBLE) begin
            die1_next = step_one(die1);
            die2_next = step_two(die2, lfsr[0]);
        end
    end

    // Output registers: all outputs come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            die1  <= 3'd1;
            die2  <= 3'd1;
            busy  <= 1'b0;
            valid <= 1'b0;
        end else begin
            die1  <= die1_next;
            die2  <= die2_next;
            busy  <= busy_next;
            valid <= valid_next;
        end
    end

`ifdef DICE_SUM_EN
    // Sum register tracks the dice so it always equals die1+die2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= 4'd2;
        end else begin
            sum <= {1'b0, die1_next} + {1'b0, die2_next};
        end
    end
`endif

endmodule

// File: tb/tb_dice_roller.sv
// Bench for dice_roller: directed scenarios (reset, first roll, hold,
// roll-while-busy, async reset mid-tumble) plus a random roll/ready run
// checking face range and die2 face distribution.
// Build with DICE_SUM_EN defined to also cover the sum output.

module tb_dice_roller;

  localparam int NROLLS = 6000;

  logic       clk;
  logic       rst_n;
  logic       roll;
  logic       ready;
  logic       busy;
  logic       valid;
  logic [2:0] die1;
  logic [2:0] die2;
`ifdef DICE_SUM_EN
  logic [3:0] sum;
`endif

  int checks;
  int errors;

  // expected results (die1) of accepted rolls, oldest first
  logic [2:0] exp_q[$];

  // bench-side record of the last result, computed by the bench
  logic [2:0] g_die1;
  logic [2:0] g_die2;

  // reference LFSR, free-running like the design's
  logic [15:0] m_lfsr;

  dice_roller #(
    .SEED(16'hACE1),
    .SETTLE_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .roll(roll),
    .ready(ready),
    .busy(busy),
    .valid(valid),
    .die1(die1),
    .die2(die2)
`ifdef DICE_SUM_EN
    ,
    .sum(sum)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  function automatic logic [2:0] ref_step1(input logic [2:0] d);
    return (d == 3'd6) ? 3'd1 : d + 3'd1;
  endfunction

  function automatic logic [2:0] ref_step2(input logic [2:0] d, input logic two);
    logic [2:0] r;
    r = ref_step1(d);
    if (two) r = ref_step1(r);
    return r;
  endfunction

  function automatic bit in_range(input logic [2:0] d);
    return (d >= 3'd1) && (d <= 3'd6);
  endfunction

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    roll  = 1'b0;
    ready = 1'b0;
    tick();
    tick();
    checks++;
    if (die1 !== 3'd1 || die2 !== 3'd1 || valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: got d1=%0d d2=%0d v=%b b=%b expected 1 1 0 0", die1, die2, valid, busy);
    end
    #3 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (die1 !== 3'd1 || die2 !== 3'd1 || valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: got d1=%0d d2=%0d v=%b b=%b expected 1 1 0 0", i, die1, die2, valid, busy);
      end
`ifdef DICE_SUM_EN
      checks++;
      if (sum !== 4'd2) begin
        errors++;
        $display("FAIL reset_sum[%0d]: got %0d expected 2", i, sum);
      end
`endif
    end
    g_die1 = 3'd1;
    g_die2 = 3'd1;
  endtask

  // starting from dice 1/1: die1 must land on 3 after 8 steps
  task automatic test_first_roll(input string name);
    logic [2:0] e2;
    e2 = 3'd1;
    roll = 1'b1;
    tick();
    roll = 1'b0;
    checks++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy: got b=%b v=%b expected b=1 v=0", name, busy, valid);
    end
    for (int i = 1; i <= 8; i++) begin
      e2 = ref_step2(e2, m_lfsr[0]);
      tick();
      if (i < 8) begin
        checks++;
        if (valid !== 1'b0) begin
          errors++;
          $display("FAIL %s_valid_early[%0d]: got %b expected 0", name, i, valid);
        end
      end
    end
    checks++;
    if (valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid: got v=%b b=%b expected 1 1", name, valid, busy);
    end
    checks++;
    if (die1 !== 3'd3) begin
      errors++;
      $display("FAIL %s_die1: got %0d expected 3", name, die1);
    end
    checks++;
    if (die2 !== e2) begin
      errors++;
      $display("FAIL %s_die2: got %0d expected %0d", name, die2, e2);
    end
    g_die1 = 3'd3;
    g_die2 = e2;
  endtask

  task automatic test_hold();
    ready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if (valid !== 1'b1 || busy !== 1'b1 || die1 !== g_die1 || die2 !== g_die2) begin
        errors++;
        $display("FAIL hold[%0d]: got v=%b b=%b d1=%0d d2=%0d expected 1 1 %0d %0d",
                 i, valid, busy, die1, die2, g_die1, g_die2);
      end
`ifdef DICE_SUM_EN
      checks++;
      if (sum !== 4'(g_die1) + 4'(g_die2)) begin
        errors++;
        $display("FAIL hold_sum[%0d]: got %0d expected %0d", i, sum, 4'(g_die1) + 4'(g_die2));
      end
`endif
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || die1 !== g_die1 || die2 !== g_die2) begin
      errors++;
      $display("FAIL hold_release: got v=%b b=%b d1=%0d d2=%0d expected 0 0 %0d %0d",
               valid, busy, die1, die2, g_die1, g_die2);
    end
    tick();
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_idle: got v=%b b=%b expected 0 0", valid, busy);
    end
  endtask

  task automatic test_roll_while_busy();
    logic [2:0] e1;
    logic [2:0] e2;
    e1 = g_die1;
    e2 = g_die2;
    roll = 1'b1;
    tick();
    roll = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      roll = (i == 3 || i == 4);
      e1 = ref_step1(e1);
      e2 = ref_step2(e2, m_lfsr[0]);
      tick();
      if (i < 8) begin
        checks++;
        if (valid !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_roll_tumble[%0d]: got v=%b b=%b expected 0 1", i, valid, busy);
        end
      end
    end
    roll = 1'b0;
    checks++;
    if (valid !== 1'b1 || die1 !== e1 || die2 !== e2) begin
      errors++;
      $display("FAIL busy_roll_result: got v=%b d1=%0d d2=%0d expected 1 %0d %0d", valid, die1, die2, e1, e2);
    end
    // roll alone in HOLD
    roll = 1'b1;
    tick();
    roll = 1'b0;
    checks++;
    if (valid !== 1'b1 || busy !== 1'b1 || die1 !== e1 || die2 !== e2) begin
      errors++;
      $display("FAIL busy_roll_hold: got v=%b b=%b d1=%0d d2=%0d expected 1 1 %0d %0d",
               valid, busy, die1, die2, e1, e2);
    end
    // roll together with ready: transfer only
    roll  = 1'b1;
    ready = 1'b1;
    tick();
    roll  = 1'b0;
    ready = 1'b0;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || die1 !== e1 || die2 !== e2) begin
      errors++;
      $display("FAIL roll_ready_xfer: got v=%b b=%b d1=%0d d2=%0d expected 0 0 %0d %0d",
               valid, busy, die1, die2, e1, e2);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL roll_ready_ignored: got b=%b v=%b expected 0 0", busy, valid);
    end
    g_die1 = e1;
    g_die2 = e2;
  endtask

  task automatic test_reset_mid_tumble();
    roll = 1'b1;
    tick();
    roll = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (die1 !== 3'd1 || die2 !== 3'd1 || valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got d1=%0d d2=%0d v=%b b=%b expected 1 1 0 0", die1, die2, valid, busy);
    end
    #1 rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || die1 !== 3'd1 || die2 !== 3'd1) begin
      errors++;
      $display("FAIL after_reset_idle: got b=%b v=%b d1=%0d d2=%0d expected 0 0 1 1", busy, valid, die1, die2);
    end
    g_die1 = 3'd1;
    g_die2 = 3'd1;
  endtask

  task automatic test_random();
    int faces[6];
    int budget;
    int lo;
    int hi;
    logic [2:0] e1;
    logic [2:0] got;
    for (int f = 0; f < 6; f++) faces[f] = 0;
    e1 = g_die1;
    for (int n = 0; n < NROLLS; n++) begin
      repeat ($urandom_range(0, 1)) tick();
      roll = 1'b1;
      tick();
      roll = 1'b0;
      for (int s = 0; s < 8; s++) e1 = ref_step1(e1);
      exp_q.push_back(e1);
      budget = 0;
      while (valid !== 1'b1 && budget < 20) begin
        checks++;
        if (!in_range(die1) || !in_range(die2)) begin
          errors++;
          $display("FAIL rand_range_tumble: got d1=%0d d2=%0d expected 1..6", die1, die2);
        end
`ifdef DICE_SUM_EN
        checks++;
        if (sum !== 4'(die1) + 4'(die2)) begin
          errors++;
          $display("FAIL rand_sum: got %0d expected %0d", sum, 4'(die1) + 4'(die2));
        end
`endif
        tick();
        budget++;
      end
      checks++;
      if (valid !== 1'b1) begin
        errors++;
        $display("FAIL rand_timeout: got valid=%b expected 1 within 20 clocks", valid);
        break;
      end
      repeat ($urandom_range(0, 2)) begin
        tick();
        checks++;
        if (valid !== 1'b1) begin
          errors++;
          $display("FAIL rand_valid_hold: got %b expected 1", valid);
        end
      end
      got = exp_q.pop_front();
      checks++;
      if (die1 !== got || !in_range(die2)) begin
        errors++;
        $display("FAIL rand_result: got d1=%0d d2=%0d expected d1=%0d d2 in 1..6", die1, die2, got);
      end
      if (in_range(die2)) faces[int'(die2) - 1]++;
      ready = 1'b1;
      tick();
      ready = 1'b0;
      checks++;
      if (valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rand_xfer: got v=%b b=%b expected 0 0", valid, busy);
      end
    end
    lo = (NROLLS / 6) * 85 / 100;
    hi = (NROLLS / 6) * 115 / 100;
    for (int f = 0; f < 6; f++) begin
      checks++;
      if (faces[f] < lo || faces[f] > hi) begin
        errors++;
        $display("FAIL die2_face%0d_count: got %0d expected %0d..%0d", f + 1, faces[f], lo, hi);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    roll   = 1'b0;
    ready  = 1'b0;
    test_reset();
    test_first_roll("first_roll");
    test_hold();
    test_roll_while_busy();
    test_reset_mid_tumble();
    test_first_roll("reroll_after_reset");
    ready = 1'b1;
    tick();
    ready = 1'b0;
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
